// File: rtl/i2s_rx_pingpong_buf_pkg.sv
// Shared types and defaults for the I2S Rx ping-pong frame buffer.
// Holds the writer FSM encoding and default geometry.
// No logic of its own.
package i2s_rx_pingpong_buf_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } wr_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_NUM_CH = 2;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/i2s_rx_bank_ram.sv
// Simple dual-port sample RAM holding both banks of one channel, address {bank, idx}.
// Latency: synchronous write; read data registered 1 cycle after re, held while re=0.
// Backpressure: none, both ports accept every cycle.
module i2s_rx_bank_ram
  import i2s_rx_pingpong_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdat,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdat <= '0;
    end else if (re) begin
      rdat <= mem[raddr];
    end
  end

endmodule

// File: rtl/i2s_rx_pingpong_buf.sv
// Multi-channel ping-pong frame buffer between the I2S Rx deserialiser and the FIR consumer.
// Latency: f_start_o 1 cycle after the frame-completing write (or after f_ack_i from HOLD); reads 1 cycle.
// Backpressure: none upstream; while both banks are full, sample-sets are dropped and counted as overrun.
module i2s_rx_pingpong_buf
  import i2s_rx_pingpong_buf_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  BIT_REV = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     WBs_CLK_i,
  input  logic                     WBs_RST_i,
  input  logic                     clr_i,
  input  logic [NUM_CH*DATA_W-1:0] rx_dat_i,
  input  logic                     rx_wr_i,
  output logic                     f_start_o,
  output logic                     f_bank_o,
  output logic                     f_rdy_o,
  input  logic                     f_ack_i,
  input  logic                     rd_en_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [DATA_W-1:0]        rd_dat_o,
  output logic                     rd_vld_o,
  output logic [ADDR_W:0]          wr_cnt_o,
  output logic                     ovr_o,
  input  logic                     ovr_clr_i,
  output logic [15:0]              drop_cnt_o
);

  wr_state_e         state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_rev, wr_idx;
  logic              wr_bank;
  logic              f_bank, f_rdy, f_start;
  logic              ovr;
  logic [15:0]       drop_cnt;
  logic              rd_vld;
  logic [CH_W-1:0]   rd_ch_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] ram_q [NUM_CH];

  logic soft_rst, wr_last, ack_ok;
  logic do_wr, do_swap, do_drop;

  assign soft_rst = WBs_RST_i | clr_i;
  assign wr_last  = (wr_ptr == {ADDR_W{1'b1}});
  assign ack_ok   = f_ack_i & f_rdy;

  for (genvar b = 0; b < ADDR_W; b++) begin : g_rev
    assign wr_ptr_rev[b] = wr_ptr[ADDR_W-1-b];
  end
  assign wr_idx = (BIT_REV != 0) ? wr_ptr_rev : wr_ptr;

  always_ff @(posedge WBs_CLK_i) begin
    if (soft_rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack arriving with the frame-completing write frees the bank in time to swap.
  always_comb begin
    state_nxt = state;
    do_wr     = 1'b0;
    do_swap   = 1'b0;
    do_drop   = 1'b0;
    case (state)
      ST_FILL: begin
        if (rx_wr_i) begin
          do_wr = 1'b1;
          if (wr_last) begin
            if (!f_rdy || f_ack_i) begin
              do_swap = 1'b1;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        do_drop = rx_wr_i;
        if (ack_ok) begin
          do_swap   = 1'b1;
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (soft_rst) begin
      wr_ptr   <= '0;
      wr_bank  <= 1'b0;
      f_bank   <= 1'b0;
      f_rdy    <= 1'b0;
      f_start  <= 1'b0;
      ovr      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      f_start <= do_swap;
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_swap) begin
        f_bank  <= wr_bank;
        wr_bank <= ~wr_bank;
        wr_ptr  <= '0;
        f_rdy   <= 1'b1;
      end else if (ack_ok) begin
        f_rdy <= 1'b0;
      end
      // A drop in the same cycle as ovr_clr_i restarts the count at one.
      if (do_drop) begin
        ovr <= 1'b1;
        if (ovr_clr_i) begin
          drop_cnt <= 16'd1;
        end else if (drop_cnt != DROP_CNT_MAX) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (ovr_clr_i) begin
        ovr      <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    i2s_rx_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk   (WBs_CLK_i),
      .rst   (soft_rst),
      .we    (do_wr),
      .waddr ({wr_bank, wr_idx}),
      .wdat  (rx_dat_i[c*DATA_W +: DATA_W]),
      .re    (rd_en_i),
      .raddr ({f_bank, rd_addr_i}),
      .rdat  (ram_q[c])
    );
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (soft_rst) begin
      rd_vld  <= 1'b0;
      rd_ch_q <= '0;
    end else begin
      rd_vld <= rd_en_i;
      if (rd_en_i) begin
        rd_ch_q <= rd_ch_i;
      end
    end
  end

  // Channel selects beyond NUM_CH match no RAM and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_ch_q) == c) begin
        rd_mux = ram_q[c];
      end
    end
  end

  assign f_start_o  = f_start;
  assign f_bank_o   = f_bank;
  assign f_rdy_o    = f_rdy;
  assign rd_dat_o   = rd_mux;
  assign rd_vld_o   = rd_vld;
  assign wr_cnt_o   = (state == ST_HOLD) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, wr_ptr};
  assign ovr_o      = ovr;
  assign drop_cnt_o = drop_cnt;

endmodule
